// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle sequencer and the shared datapath.
// master = the control unit, slave = the datapath side.
interface multicycle_control_unit_if #(
  parameter int ALUOP_W = 3
);
  logic [5:0]         OpCode;
  logic               MemReady;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               IRWrite;
  logic               MemRead;
  logic               MemWrite;
  logic               MemtoReg;
  logic               RegDst;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         PCSource;
  logic               BranchNe;
  logic [ALUOP_W-1:0] ALUOp;
  logic               InstrDone;
  logic               IllegalOp;
  logic               Halted;

  modport master (
    input  OpCode, MemReady,
    output PCWrite, PCWriteCond, IorD, IRWrite,
    output MemRead, MemWrite, MemtoReg, RegDst,
    output RegWrite, ALUSrcA, ALUSrcB, PCSource,
    output BranchNe, ALUOp, InstrDone, IllegalOp,
    output Halted
  );

  modport slave (
    output OpCode, MemReady,
    input  PCWrite, PCWriteCond, IorD, IRWrite,
    input  MemRead, MemWrite, MemtoReg, RegDst,
    input  RegWrite, ALUSrcA, ALUSrcB, PCSource,
    input  BranchNe, ALUOp, InstrDone, IllegalOp,
    input  Halted
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing
// with MemReady stalls and a trap-or-skip policy for illegal opcodes.
module multicycle_control_unit #(
  parameter int ALUOP_W         = 3,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  multicycle_control_unit_if.master bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [ALUOP_W-1:0] AOP_ADD = '0;
  localparam logic [ALUOP_W-1:0] AOP_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AOP_FN  = ALUOP_W'(2);

  typedef enum logic [3:0] {
    S_RST_IDLE, S_FETCH,  S_DECODE, S_EXEC_R,
    S_R_WB,     S_EXEC_I, S_I_WB,   S_MEM_ADDR,
    S_MEM_RD,   S_LW_WB,  S_MEM_WR, S_BRANCH,
    S_JUMP,     S_HALT
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op;

  logic w_is_r, w_is_mem, w_is_br, w_is_i, w_is_j;

  assign w_is_r   = bus.OpCode == OP_R;
  assign w_is_mem = bus.OpCode == OP_LW || bus.OpCode == OP_SW;
  assign w_is_br  = bus.OpCode == OP_BEQ || bus.OpCode == OP_BNE;
  assign w_is_i   = bus.OpCode == OP_ADDI;
  assign w_is_j   = bus.OpCode == OP_J;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RST_IDLE;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_op <= bus.OpCode;
    end
  end

  always_comb begin
    w_next          = r_state;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.PCSource    = 2'b00;
    bus.BranchNe    = 1'b0;
    bus.ALUOp       = AOP_ADD;
    bus.InstrDone   = 1'b0;
    bus.IllegalOp   = 1'b0;
    bus.Halted      = 1'b0;
    unique case (r_state)
      S_RST_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
        if (bus.MemReady) w_next = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'b11;
        unique case (1'b1)
          w_is_r:   w_next = S_EXEC_R;
          w_is_mem: w_next = S_MEM_ADDR;
          w_is_br:  w_next = S_BRANCH;
          w_is_i:   w_next = S_EXEC_I;
          w_is_j:   w_next = S_JUMP;
          default: begin
            bus.IllegalOp = 1'b1;
            w_next = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = AOP_FN;
        w_next      = S_R_WB;
      end
      S_R_WB: begin
        bus.RegDst    = 1'b1;
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
        w_next        = S_FETCH;
      end
      S_EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        w_next      = S_I_WB;
      end
      S_I_WB: begin
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
        w_next        = S_FETCH;
      end
      S_MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        w_next = (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.MemReady) w_next = S_LW_WB;
      end
      S_LW_WB: begin
        bus.MemtoReg  = 1'b1;
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
        w_next        = S_FETCH;
      end
      S_MEM_WR: begin
        bus.MemWrite  = 1'b1;
        bus.IorD      = 1'b1;
        bus.InstrDone = bus.MemReady;
        if (bus.MemReady) w_next = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = AOP_SUB;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        bus.BranchNe    = r_op == OP_BNE;
        bus.InstrDone   = 1'b1;
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        bus.PCWrite   = 1'b1;
        bus.PCSource  = 2'b10;
        bus.InstrDone = 1'b1;
        w_next        = S_FETCH;
      end
      S_HALT: bus.Halted = 1'b1;
      default: w_next = S_RST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: one trapping and one skipping
// instance, checked cycle by cycle against a phase-table reference.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pcw, pcwc, iord, irw, mrd, mwr, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic       bne;
    logic [2:0] aop;
    logic       done, ill, halt;
  } ctl_t;

  localparam int P_IDLE = 0,  P_FETCH = 1, P_DEC = 2,  P_EXR = 3;
  localparam int P_RWB  = 4,  P_EXI   = 5, P_IWB = 6,  P_MA  = 7;
  localparam int P_MRD  = 8,  P_LWB   = 9, P_MWR = 10, P_BR  = 11;
  localparam int P_J    = 12, P_HALT  = 13;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.ALUOP_W(3)) b0 ();
  multicycle_control_unit_if #(.ALUOP_W(3)) b1 ();

  multicycle_control_unit #(.ALUOP_W(3), .TRAP_ON_ILLEGAL(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  multicycle_control_unit #(.ALUOP_W(3), .TRAP_ON_ILLEGAL(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(b1));

  ctl_t obs0, obs1;
  assign obs0 = {b0.PCWrite, b0.PCWriteCond, b0.IorD, b0.IRWrite,
                 b0.MemRead, b0.MemWrite, b0.MemtoReg, b0.RegDst,
                 b0.RegWrite, b0.ALUSrcA, b0.ALUSrcB, b0.PCSource,
                 b0.BranchNe, b0.ALUOp, b0.InstrDone, b0.IllegalOp,
                 b0.Halted};
  assign obs1 = {b1.PCWrite, b1.PCWriteCond, b1.IorD, b1.IRWrite,
                 b1.MemRead, b1.MemWrite, b1.MemtoReg, b1.RegDst,
                 b1.RegWrite, b1.ALUSrcA, b1.ALUSrcB, b1.PCSource,
                 b1.BranchNe, b1.ALUOp, b1.InstrDone, b1.IllegalOp,
                 b1.Halted};

  int checks = 0;
  int errors = 0;
  int ph [2];
  logic [5:0] lop [2];
  logic [5:0] legal_ops [7] = '{6'b000000, 6'b100011, 6'b101011,
                                6'b000100, 6'b000101, 6'b001000,
                                6'b000010};

  function automatic bit legal(logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                      6'b000101, 6'b001000, 6'b000010};
  endfunction

  function automatic ctl_t expv(int p, logic [5:0] lo, logic mr,
                                logic [5:0] dop);
    ctl_t c = '0;
    case (p)
      P_FETCH: begin c.mrd = 1; c.asb = 2'b01; c.irw = mr; c.pcw = mr; end
      P_DEC:   begin c.asb = 2'b11; c.ill = !legal(dop); end
      P_EXR:   begin c.asa = 1; c.aop = 3'd2; end
      P_RWB:   begin c.rdst = 1; c.rw = 1; c.done = 1; end
      P_EXI:   begin c.asa = 1; c.asb = 2'b10; end
      P_IWB:   begin c.rw = 1; c.done = 1; end
      P_MA:    begin c.asa = 1; c.asb = 2'b10; end
      P_MRD:   begin c.mrd = 1; c.iord = 1; end
      P_LWB:   begin c.m2r = 1; c.rw = 1; c.done = 1; end
      P_MWR:   begin c.mwr = 1; c.iord = 1; c.done = mr; end
      P_BR: begin
        c.asa = 1; c.aop = 3'd1; c.pcwc = 1; c.pcs = 2'b01;
        c.done = 1; c.bne = (lo == 6'b000101);
      end
      P_J:     begin c.pcw = 1; c.pcs = 2'b10; c.done = 1; end
      P_HALT:  c.halt = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic int nextp(int p, logic [5:0] dop, logic [5:0] lo,
                               logic mr, bit trap);
    case (p)
      P_IDLE:  return P_FETCH;
      P_FETCH: return mr ? P_DEC : P_FETCH;
      P_DEC: begin
        case (dop)
          6'b000000: return P_EXR;
          6'b100011, 6'b101011: return P_MA;
          6'b000100, 6'b000101: return P_BR;
          6'b001000: return P_EXI;
          6'b000010: return P_J;
          default:   return trap ? P_HALT : P_FETCH;
        endcase
      end
      P_EXR:   return P_RWB;
      P_EXI:   return P_IWB;
      P_MA:    return (lo == 6'b100011) ? P_MRD : P_MWR;
      P_MRD:   return mr ? P_LWB : P_MRD;
      P_MWR:   return mr ? P_FETCH : P_MWR;
      P_HALT:  return P_HALT;
      default: return P_FETCH;
    endcase
  endfunction

  function automatic int base_cycles(logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b000000, 6'b101011, 6'b001000: return 4;
      6'b000100, 6'b000101, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic step(input logic r, input logic m, input logic [5:0] op);
    ctl_t e0, e1;
    int np;
    @(negedge clk);
    rst = r;
    b0.MemReady = m; b1.MemReady = m;
    b0.OpCode = op;  b1.OpCode = op;
    #1;
    e0 = expv(ph[0], lop[0], m, op);
    e1 = expv(ph[1], lop[1], m, op);
    checks++;
    assert (obs0 === e0) else begin
      errors++;
      $error("FAIL ctl_skip phase=%0d observed=%h expected=%h",
             ph[0], obs0, e0);
    end
    checks++;
    assert (obs1 === e1) else begin
      errors++;
      $error("FAIL ctl_trap phase=%0d observed=%h expected=%h",
             ph[1], obs1, e1);
    end
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        ph[k] = P_IDLE;
        lop[k] = '0;
      end else begin
        np = nextp(ph[k], op, lop[k], m, k == 1);
        if (ph[k] == P_DEC) lop[k] = op;
        ph[k] = np;
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 6'($urandom));
    step(1'b1, 1'b1, 6'($urandom));
    step(1'b0, 1'b1, 6'($urandom));
    checks++;
    assert (obs0 === '0 && obs1 === '0) else begin
      errors++;
      $error("FAIL reset_idle observed=%h/%h expected=0", obs0, obs1);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int fs,
                           input int ms, output int cyc);
    int f, s, expc;
    bit fin;
    logic m;
    f = fs; s = ms; cyc = 0; fin = 0;
    for (int i = 0; i < 64 && !fin; i++) begin
      m = 1'b1;
      if (ph[0] == P_FETCH && f > 0) begin m = 1'b0; f--; end
      else if ((ph[0] == P_MRD || ph[0] == P_MWR) && s > 0) begin
        m = 1'b0; s--;
      end
      step(1'b0, m, ph[0] == P_DEC ? op : 6'($urandom));
      cyc++;
      if (obs0.done === 1'b1 || obs0.ill === 1'b1) fin = 1;
    end
    expc = base_cycles(op) + fs;
    if (op == 6'b100011 || op == 6'b101011) expc += ms;
    checks++;
    assert (fin && cyc == expc) else begin
      errors++;
      $error("FAIL cycles op=%b observed=%0d expected=%0d", op, cyc, expc);
    end
  endtask

  initial begin
    int c, tot;
    logic [5:0] op;
    rst = 1'b1;
    b0.MemReady = 1'b1; b1.MemReady = 1'b1;
    b0.OpCode = '0;     b1.OpCode = '0;
    ph = '{P_IDLE, P_IDLE};
    lop = '{6'd0, 6'd0};

    do_reset();
    foreach (legal_ops[i]) run_instr(legal_ops[i], 0, 0, c);
    run_instr(6'b100011, 3, 2, c);
    checks++;
    assert (c == 10) else begin
      errors++;
      $error("FAIL lw_stall observed=%0d expected=10", c);
    end

    do_reset();
    run_instr(6'b111111, 0, 0, c);
    tot = 0;
    while (tot < 20) begin
      run_instr(legal_ops[$urandom_range(0, 6)], 0, 0, c);
      tot += c;
    end

    do_reset();
    run_instr(6'b000110, 0, 0, c);
    run_instr(6'b000100, 0, 0, c);

    do_reset();
    step(1'b0, 1'b1, 6'($urandom));
    step(1'b0, 1'b1, 6'b101011);
    step(1'b0, 1'b1, 6'($urandom));
    step(1'b0, 1'b0, 6'($urandom));
    step(1'b0, 1'b0, 6'($urandom));
    step(1'b1, 1'b0, 6'($urandom));
    step(1'b0, 1'b1, 6'($urandom));
    checks++;
    assert (obs0.mwr === 1'b0 && obs0 === '0) else begin
      errors++;
      $error("FAIL rst_mid_wr observed=%h expected=0", obs0);
    end
    step(1'b0, 1'b1, 6'($urandom));

    do_reset();
    for (int n = 0; n < 200; n++) begin
      if (n % 40 == 39) do_reset();
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 6)];
      end
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
